// File: rtl/pe_dmem_dma.sv
// pe_dmem_dma: block-transfer engine that masters the bus port of a PE data memory,
// moving a contiguous run of words between a valid/ready stream and the memory.
module pe_dmem_dma #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int RAM_ADDR_BITS = 10,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCmd_Valid,
  output logic                  oCmd_Ready,
  input  logic                  iCmd_Write,
  input  logic [ADDR_WIDTH-1:0] iCmd_Base_Address,
  input  logic [LEN_WIDTH-1:0]  iCmd_Length,
  output logic                  oBusy,
  output logic                  oDone,
  input  logic                  iIn_Valid,
  output logic                  oIn_Ready,
  input  logic [DATA_WIDTH-1:0] iIn_Data,
  output logic                  oOut_Valid,
  input  logic                  iOut_Ready,
  output logic [DATA_WIDTH-1:0] oOut_Data,
  output logic                  oBus_Valid,
  output logic [ADDR_WIDTH-1:0] oBus_Address,
  output logic [DATA_WIDTH-1:0] oBus_Write_Data,
  output logic                  oBus_Write_Enable,
  input  logic [DATA_WIDTH-1:0] iBus_Read_Data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic [RAM_ADDR_BITS-1:0] wordIdx;
  logic [LEN_WIDTH-1:0]     remaining;
  logic                     wrValid;
  logic [ADDR_WIDTH-1:0]    wrAddr;
  logic [DATA_WIDTH-1:0]    wrData;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    fifoMem [2];
  logic                     wrPtr;
  logic                     rdPtr;
  logic [1:0]               fifoCount;
  logic                     cmdFire;
  logic                     inFire;
  logic                     pop;
  logic                     readIssue;
  logic [2:0]               occupancy;
  logic [ADDR_WIDTH-1:0]    idxAddr;
  logic                     unusedAddrBits;

  assign cmdFire = iCmd_Valid && (state == IDLE);
  assign inFire  = iIn_Valid && oIn_Ready;
  assign pop     = oOut_Valid && iOut_Ready;

  // Word count the FIFO will hold after this cycle; a new read is only safe while
  // that leaves room for the word it returns one cycle later.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inflight} - {2'b00, pop};

  // Reads go onto the bus in the same cycle they are decided, so the first one lands
  // right after the command and back-to-back reads sustain one word per cycle.
  assign readIssue = (state == READ) && (remaining != '0) && (occupancy <= 3'd1) && !iReset;

  assign unusedAddrBits = ^iCmd_Base_Address;

  // Byte address of the current word: index in the middle, zero byte offset, zero above.
  always_comb begin
    idxAddr = '0;
    idxAddr[RAM_ADDR_BITS+1:2] = wordIdx;
  end

  assign oCmd_Ready        = (state == IDLE);
  assign oBusy             = (state != IDLE);
  assign oDone             = (state == DONE);
  assign oIn_Ready         = (state == WRITE) && (remaining != '0);
  assign oOut_Valid        = (fifoCount != 2'd0);
  assign oOut_Data         = fifoMem[rdPtr];
  assign oBus_Valid        = wrValid || readIssue;
  assign oBus_Address      = readIssue ? idxAddr : wrAddr;
  assign oBus_Write_Data   = wrData;
  assign oBus_Write_Enable = wrValid;

  // Transfer sequencing: command latch, write registration, read issue and completion.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= IDLE;
      wordIdx   <= '0;
      remaining <= '0;
      wrValid   <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
    end else begin
      wrValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmdFire) begin
            wordIdx   <= iCmd_Base_Address[RAM_ADDR_BITS+1:2];
            remaining <= iCmd_Length;
            if (iCmd_Length == '0) state <= DONE;
            else if (iCmd_Write)   state <= WRITE;
            else                   state <= READ;
          end
        end
        WRITE: begin
          if (inFire) begin
            wrValid   <= 1'b1;
            wrAddr    <= idxAddr;
            wrData    <= iIn_Data;
            wordIdx   <= wordIdx + RAM_ADDR_BITS'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end else if (remaining == '0) begin
            state <= DONE;
          end
        end
        READ: begin
          if (readIssue) begin
            wordIdx   <= wordIdx + RAM_ADDR_BITS'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end else if (remaining == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (occupancy == 3'd0) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry read-return FIFO, filled the cycle after each bus read.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      inflight   <= 1'b0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      fifoCount  <= 2'd0;
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
    end else begin
      inflight <= readIssue;
      if (inflight) begin
        fifoMem[wrPtr] <= iBus_Read_Data;
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCount <= occupancy[1:0];
    end
  end

endmodule

// File: tb/tb_pe_dmem_dma.sv
// tb_pe_dmem_dma: directed, table-driven bench for pe_dmem_dma with a 1-cycle memory model.
module tb_pe_dmem_dma;

  localparam int DW     = 32;
  localparam int AW     = 12;
  localparam int LW     = 11;
  localparam int BUDGET = 100;

  logic          iClk = 1'b0;
  logic          iReset = 1'b1;
  logic          iCmd_Valid = 1'b0;
  logic          oCmd_Ready;
  logic          iCmd_Write = 1'b0;
  logic [AW-1:0] iCmd_Base_Address = '0;
  logic [LW-1:0] iCmd_Length = '0;
  logic          oBusy;
  logic          oDone;
  logic          iIn_Valid = 1'b0;
  logic          oIn_Ready;
  logic [DW-1:0] iIn_Data = '0;
  logic          oOut_Valid;
  logic          iOut_Ready = 1'b0;
  logic [DW-1:0] oOut_Data;
  logic          oBus_Valid;
  logic [AW-1:0] oBus_Address;
  logic [DW-1:0] oBus_Write_Data;
  logic          oBus_Write_Enable;
  logic [DW-1:0] iBus_Read_Data = '0;

  pe_dmem_dma dut (
    .iClk(iClk), .iReset(iReset),
    .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Write(iCmd_Write),
    .iCmd_Base_Address(iCmd_Base_Address), .iCmd_Length(iCmd_Length),
    .oBusy(oBusy), .oDone(oDone),
    .iIn_Valid(iIn_Valid), .oIn_Ready(oIn_Ready), .iIn_Data(iIn_Data),
    .oOut_Valid(oOut_Valid), .iOut_Ready(iOut_Ready), .oOut_Data(oOut_Data),
    .oBus_Valid(oBus_Valid), .oBus_Address(oBus_Address), .oBus_Write_Data(oBus_Write_Data),
    .oBus_Write_Enable(oBus_Write_Enable), .iBus_Read_Data(iBus_Read_Data)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic                 write;
    logic [AW-1:0]        base;
    logic [LW-1:0]        len;
    logic [DW-1:0]        dataBase;
    logic [3:0]           readyPat;
    logic                 consecutive;
    int                   expDoneOff;
    logic [7:0][AW-1:0]   expAddr;
  } vec_t;

  typedef struct {
    int            cycle;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } busRec_t;

  vec_t          vecs [8];
  busRec_t       busLog [$];
  busRec_t       rec;
  int            popCyc [$];
  logic [DW-1:0] popData [$];
  int            doneCyc [$];
  int            cyc = 0;
  int            issued = 0;
  int            popped = 0;
  bit            occErr = 1'b0;
  int            nChecks = 0;
  int            nFails = 0;
  logic [DW-1:0] mem [0:1023];

  // Cycle counter; cycle c is the interval following the c-th rising edge.
  always @(posedge iClk) cyc <= cyc + 1;

  // Data memory with one cycle of read latency.
  always @(posedge iClk) begin
    if (oBus_Valid) begin
      if (oBus_Write_Enable) mem[oBus_Address[11:2]] <= oBus_Write_Data;
      else                   iBus_Read_Data <= mem[oBus_Address[11:2]];
    end
  end

  // Mid-cycle monitor logging bus accesses, output handshakes, done pulses and read backlog.
  always @(negedge iClk) begin
    if (issued - popped > 3) occErr = 1'b1;
    if (oBus_Valid) begin
      rec.cycle = cyc;
      rec.addr  = oBus_Address;
      rec.data  = oBus_Write_Data;
      rec.we    = oBus_Write_Enable;
      busLog.push_back(rec);
      if (!oBus_Write_Enable) issued++;
    end
    if (oOut_Valid && iOut_Ready) begin
      popCyc.push_back(cyc);
      popData.push_back(oOut_Data);
      popped++;
    end
    if (oDone) doneCyc.push_back(cyc);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " oCmd_Ready"}, oCmd_Ready, 1);
    checkOutput({tag, " oBusy"}, oBusy, 0);
    checkOutput({tag, " oDone"}, oDone, 0);
    checkOutput({tag, " oIn_Ready"}, oIn_Ready, 0);
    checkOutput({tag, " oOut_Valid"}, oOut_Valid, 0);
    checkOutput({tag, " oOut_Data"}, oOut_Data, 0);
    checkOutput({tag, " oBus_Valid"}, oBus_Valid, 0);
    checkOutput({tag, " oBus_Address"}, 32'(oBus_Address), 0);
    checkOutput({tag, " oBus_Write_Data"}, oBus_Write_Data, 0);
    checkOutput({tag, " oBus_Write_Enable"}, oBus_Write_Enable, 0);
  endtask

  task automatic clearLogs();
    busLog.delete();
    popCyc.delete();
    popData.delete();
    doneCyc.delete();
    issued = 0;
    popped = 0;
    occErr = 1'b0;
  endtask

  // Issue one command and run the streams until one cycle after oDone.
  task automatic applyStimulus(input vec_t v, output int tCmd);
    int k;
    bit doneSeen;
    bit finished;
    clearLogs();
    k = 0;
    doneSeen = 1'b0;
    finished = 1'b0;
    @(posedge iClk); #1;
    iCmd_Valid = 1'b1;
    iCmd_Write = v.write;
    iCmd_Base_Address = v.base;
    iCmd_Length = v.len;
    tCmd = cyc;
    #2;
    checkOutput("cmdReadyIdle", oCmd_Ready, 1);
    for (int n = 0; n < BUDGET && !finished; n++) begin
      @(posedge iClk); #1;
      iCmd_Valid = 1'b0;
      iIn_Valid  = v.write;
      iIn_Data   = v.dataBase + k;
      iOut_Ready = v.readyPat[n % 4];
      #2;
      if (n == 0) begin
        checkOutput("cmdReadyHeldOff", oCmd_Ready, 0);
        checkOutput("busyDuringTransfer", oBusy, 1);
      end
      if (doneSeen) begin
        checkOutput("cmdReadyAfterDone", oCmd_Ready, 1);
        finished = 1'b1;
      end else begin
        if (iIn_Valid && oIn_Ready) k++;
        if (oDone) doneSeen = 1'b1;
      end
    end
    iIn_Valid  = 1'b0;
    iOut_Ready = 1'b0;
    checkOutput("transferFinished", 32'(finished), 1);
  endtask

  // Compare logged bus accesses, output words and done timing against the vector.
  task automatic checkVector(input vec_t v, input int id, input int tCmd);
    int n;
    int firstOff;
    int expDone;
    n = int'(v.len);
    firstOff = v.write ? 2 : 1;
    checkOutput($sformatf("v%0d busCount", id), busLog.size(), n);
    for (int k = 0; k < n && k < busLog.size(); k++) begin
      checkOutput($sformatf("v%0d addr%0d", id, k), 32'(busLog[k].addr), 32'(v.expAddr[k]));
      checkOutput($sformatf("v%0d we%0d", id, k), 32'(busLog[k].we), 32'(v.write));
      if (v.consecutive) checkOutput($sformatf("v%0d busCycle%0d", id, k), busLog[k].cycle, tCmd + firstOff + k);
      if (v.write) checkOutput($sformatf("v%0d wdata%0d", id, k), busLog[k].data, v.dataBase + k);
    end
    if (!v.write) begin
      checkOutput($sformatf("v%0d popCount", id), popData.size(), n);
      for (int k = 0; k < n && k < popData.size(); k++) begin
        checkOutput($sformatf("v%0d outData%0d", id, k), popData[k], v.dataBase + k);
        if (v.consecutive) checkOutput($sformatf("v%0d popCycle%0d", id, k), popCyc[k], tCmd + 3 + k);
      end
      checkOutput($sformatf("v%0d backlog", id), 32'(occErr), 0);
    end
    checkOutput($sformatf("v%0d doneCount", id), doneCyc.size(), 1);
    if (doneCyc.size() >= 1) begin
      if (v.expDoneOff >= 0) expDone = tCmd + v.expDoneOff;
      else expDone = (popCyc.size() > 0) ? popCyc[$] + 1 : -1;
      checkOutput($sformatf("v%0d doneCycle", id), doneCyc[0], expDone);
    end
  endtask

  initial begin
    int tCmd;
    int nPop;
    int resetCyc;
    int late;

    vecs[0] = '{1'b1, 12'h010, 11'd4, 32'hA0, 4'hF, 1'b1, 6,
                {48'h0, 12'h01C, 12'h018, 12'h014, 12'h010}};
    vecs[1] = '{1'b0, 12'h013, 11'd4, 32'hA0, 4'hF, 1'b1, 7,
                {48'h0, 12'h01C, 12'h018, 12'h014, 12'h010}};
    vecs[2] = '{1'b1, 12'hFF8, 11'd4, 32'hB0, 4'hF, 1'b1, 6,
                {48'h0, 12'h004, 12'h000, 12'hFFC, 12'hFF8}};
    vecs[3] = '{1'b0, 12'hFF8, 11'd4, 32'hB0, 4'hF, 1'b1, 7,
                {48'h0, 12'h004, 12'h000, 12'hFFC, 12'hFF8}};
    vecs[4] = '{1'b1, 12'h100, 11'd8, 32'hC0, 4'hF, 1'b1, 10,
                {12'h11C, 12'h118, 12'h114, 12'h110, 12'h10C, 12'h108, 12'h104, 12'h100}};
    vecs[5] = '{1'b0, 12'h100, 11'd8, 32'hC0, 4'h9, 1'b0, -1,
                {12'h11C, 12'h118, 12'h114, 12'h110, 12'h10C, 12'h108, 12'h104, 12'h100}};
    vecs[6] = '{1'b0, 12'h040, 11'd0, 32'h0, 4'hF, 1'b0, 1, 96'h0};
    vecs[7] = '{1'b1, 12'h200, 11'd2, 32'hD0, 4'hF, 1'b1, 4,
                {72'h0, 12'h204, 12'h200}};

    repeat (2) @(posedge iClk);
    #3;
    checkResetValues("initialReset");
    iReset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], tCmd);
      checkVector(vecs[i], i, tCmd);
    end

    // Reset in the middle of an eight-word read, after two words were delivered.
    clearLogs();
    nPop = 0;
    @(posedge iClk); #1;
    iCmd_Valid = 1'b1;
    iCmd_Write = 1'b0;
    iCmd_Base_Address = 12'h100;
    iCmd_Length = 11'd8;
    for (int n = 0; n < 20 && nPop < 2; n++) begin
      @(posedge iClk); #1;
      iCmd_Valid = 1'b0;
      iOut_Ready = 1'b1;
      #2;
      if (oOut_Valid && iOut_Ready) nPop++;
    end
    checkOutput("midReadPops", nPop, 2);
    @(posedge iClk); #1;
    iReset = 1'b1;
    iOut_Ready = 1'b0;
    resetCyc = cyc;
    @(posedge iClk); #1;
    iReset = 1'b0;
    #2;
    checkResetValues("midReadReset");
    @(posedge iClk); #3;
    late = 0;
    foreach (busLog[i]) if (busLog[i].cycle >= resetCyc) late++;
    checkOutput("accessAfterReset", late, 0);
    checkOutput("midReadWordCount", popData.size(), 2);
    if (popData.size() >= 2) begin
      checkOutput("midReadWord0", popData[0], 32'hC0);
      checkOutput("midReadWord1", popData[1], 32'hC1);
    end

    applyStimulus(vecs[7], tCmd);
    checkVector(vecs[7], 7, tCmd);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
